// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared CPU front-end types and the instruction queue depth.
//   uint32_t            - 32-bit unsigned word
//   virt_t              - 32-bit virtual address
//   address_exception_t - fetch address exception flags {illegal, miss}
//   pipe_if_t           - fetch packet {vaddr, inst, valid, iaddr_ex}
//   INST_QUEUE_DEPTH    - depth used by the parent when instantiating inst_queue
package inst_queue_pkg;

    typedef logic [31:0] uint32_t;
    typedef logic [31:0] virt_t;

    typedef struct packed {
        logic illegal;
        logic miss;
    } address_exception_t;

    typedef struct packed {
        virt_t              vaddr;
        uint32_t            inst;
        logic               valid;
        address_exception_t iaddr_ex;
    } pipe_if_t;

    localparam int unsigned INST_QUEUE_DEPTH = 4;

endpackage

// File: rtl/inst_queue.sv
// inst_queue: in-order buffer between instruction fetch and decode.
// Holds up to DEPTH fetch packets; the oldest one is presented to decode
// through a valid/ready handshake. flush (or rst) empties it in one cycle.
//
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   flush       - drop all contents (exception or branch redirect)
//   push_valid  - fetch packet valid
//   push_data   - fetch packet
//   push_ready  - queue can accept (depends on registered state only)
//   pop_valid   - head entry valid for decode
//   pop_data    - head entry, '0 when nothing is presented
//   pop_ready   - decode consumes the head this cycle
//   count       - occupancy
//   full, empty - count == DEPTH, count == 0
//
// Configuration macro INST_QUEUE_BYPASS_EN: when defined, a packet pushed into
// an empty queue is presented on pop_* in the same cycle, and if decode takes
// it that cycle it is never written to storage.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = INST_QUEUE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push_valid,
    input  pipe_if_t               push_data,
    output logic                   push_ready,
    output logic                   pop_valid,
    output pipe_if_t               pop_data,
    input  logic                   pop_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    pipe_if_t        mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   cnt;

    logic            do_push;
    logic            do_pop;
    logic            bypass;

    assign full       = (cnt == CW'(DEPTH));
    assign empty      = (cnt == '0);
    assign push_ready = ~full;
    assign count      = cnt;

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = empty & push_valid & ~flush & ~rst;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        pop_valid = ~empty | bypass;
        pop_data  = '0;
        if (!empty) begin
            pop_data = mem[head];
        end else if (bypass) begin
            pop_data = push_data;
        end
    end

    // A bypassed packet consumed in the same cycle never touches storage.
    // Popping is gated on stored entries only, so an empty queue never
    // moves head regardless of pop_ready.
    always_comb begin
        do_pop  = ~empty & pop_ready;
        do_push = push_valid & push_ready & ~(bypass & pop_ready);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[tail] <= push_data;
                tail      <= tail + PW'(1);
            end
            if (do_pop) begin
                head <= head + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int unsigned DEPTH = INST_QUEUE_DEPTH;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, flush, push_valid, push_ready, pop_valid, pop_ready, full, empty;
    pipe_if_t      push_data, pop_data;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_err    = 0;

    pipe_if_t q[$];

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .pop_ready  (pop_ready),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic bypass_now();
`ifdef INST_QUEUE_BYPASS_EN
        return (q.size() == 0) && push_valid && !flush && !rst;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: a queue of packets, head at index 0.
    task automatic check_outputs();
        pipe_if_t exp_data;
        exp_data = '0;
        if (q.size() != 0)     exp_data = q[0];
        else if (bypass_now()) exp_data = push_data;
        chk("count",      128'(count),      128'(q.size()));
        chk("full",       128'(full),       128'(q.size() == DEPTH));
        chk("empty",      128'(empty),      128'(q.size() == 0));
        chk("push_ready", 128'(push_ready), 128'(q.size() < DEPTH));
        chk("pop_valid",  128'(pop_valid),  128'((q.size() != 0) || bypass_now()));
        chk("pop_data",   128'(pop_data),   128'(exp_data));
    endtask

    task automatic model_update();
        bit take, put;
        if (rst || flush) begin
            q.delete();
        end else begin
            take = pop_ready && (q.size() != 0);
            put  = push_valid && (q.size() < DEPTH);
            if (bypass_now() && pop_ready) put = 1'b0;
            if (take) void'(q.pop_front());
            if (put)  q.push_back(push_data);
        end
    endtask

    // Inputs change at the falling edge; outputs checked 1ns later.
    task automatic step(input logic f, input logic pv, input pipe_if_t pd, input logic pr,
                        input bit do_check);
        flush      = f;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        #1;
        if (do_check) check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic pipe_if_t mk(input logic [31:0] va, input logic [31:0] ins,
                                    input logic [1:0] ex);
        pipe_if_t p;
        p.vaddr    = va;
        p.inst     = ins;
        p.valid    = 1'b1;
        p.iaddr_ex = ex;
        return p;
    endfunction

    pipe_if_t pkt;

    initial begin
        rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; pop_ready = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;

        // Reset state
        #1;
        chk("rst_count",      128'(count),      128'(0));
        chk("rst_empty",      128'(empty),      128'(1));
        chk("rst_full",       128'(full),       128'(0));
        chk("rst_push_ready", 128'(push_ready), 128'(1));
        chk("rst_pop_valid",  128'(pop_valid),  128'(0));
        chk("rst_pop_data",   128'(pop_data),   128'(0));
        @(negedge clk);

        // Fill with decode stalled, then a dropped 5th push
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, mk(32'hbfc00000 + 32'(4 * i), $urandom, 2'b00), 1'b0, 1'b1);
        chk("fill_count",      128'(count),      128'(4));
        chk("fill_full",       128'(full),       128'(1));
        chk("fill_push_ready", 128'(push_ready), 128'(0));
        step(1'b0, 1'b1, mk(32'hbfc00010, $urandom, 2'b00), 1'b0, 1'b1);
        chk("drop_count", 128'(count), 128'(4));
        for (int i = 0; i < 4; i++) begin
            chk("pop_order", 128'(pop_data.vaddr), 128'(32'hbfc00000 + 32'(4 * i)));
            step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        end
        chk("drain_empty", 128'(empty), 128'(1));

        // Pop on empty: no underflow
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("underflow_count", 128'(count), 128'(0));

        // Back-to-back push/pop across the pointer wrap
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, mk(32'h1000 + 32'(i), 32'(i), 2'b00), 1'b1, 1'b1);
`ifdef INST_QUEUE_BYPASS_EN
        chk("wrap_count", 128'(count), 128'(0));
`else
        chk("wrap_count", 128'(count), 128'(1));
        chk("wrap_last",  128'(pop_data.vaddr), 128'(32'h1009));
`endif
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Push and pop together while full
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, mk(32'h2000 + 32'(i), $urandom, 2'b00), 1'b0, 1'b1);
        step(1'b0, 1'b1, mk(32'h2004, $urandom, 2'b00), 1'b1, 1'b1);
        chk("fullpp_count",      128'(count),      128'(3));
        chk("fullpp_push_ready", 128'(push_ready), 128'(1));
        chk("fullpp_head",       128'(pop_data.vaddr), 128'(32'h2001));

        // Flush mid-operation with a concurrent push
        step(1'b1, 1'b1, mk(32'h3000, $urandom, 2'b00), 1'b1, 1'b1);
        chk("flush_count",     128'(count),     128'(0));
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("flush_pop_valid", 128'(pop_valid), 128'(0));
        step(1'b0, 1'b1, mk(32'h80001000, 32'h0, 2'b00), 1'b0, 1'b1);
        chk("post_flush_head", 128'(pop_data.vaddr), 128'(32'h80001000));
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Exception packet passes through untouched
        pkt = mk(32'hbfc00200, 32'h0, 2'b01);
        step(1'b0, 1'b1, pkt, 1'b0, 1'b1);
        chk("exc_data", 128'(pop_data), 128'(pkt));
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);

`ifdef INST_QUEUE_BYPASS_EN
        // Zero-latency bypass on an empty queue
        pkt = mk(32'hbfc00300, 32'h0, 2'b01);
        flush = 1'b0; push_valid = 1'b1; push_data = pkt; pop_ready = 1'b1;
        #1;
        chk("byp_pop_valid", 128'(pop_valid), 128'(1));
        chk("byp_pop_data",  128'(pop_data),  128'(pkt));
        @(negedge clk);
        step(1'b0, 1'b1, pkt, 1'b1, 1'b1);
        chk("byp_count", 128'(count), 128'(0));
`endif

        // Randomized traffic against the reference queue
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0,
                 mk($urandom, $urandom, 2'($urandom)),
                 $urandom_range(0, 2) == 0 || i > 300 && $urandom_range(0, 1) == 0,
                 1'b1);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
